// File: rtl/uart_host_ctrl.sv
// rtl/uart_host_ctrl.sv - UART host command sequencer; optional trailing checksum via UART_HOST_CSUM_EN
module uart_host_ctrl #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 8,
    parameter int RX_TIMEOUT = 270000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              tx_start,
    output logic [7:0]        tx_data,
    input  logic              tx_ready,
    output logic              mem_we,
    output logic              mem_re,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              core_start,
    input  logic              core_done,
    output logic              err_sticky
);

    localparam int TW = $clog2(RX_TIMEOUT + 1);
    localparam logic [TW-1:0]     TMO_MAX  = TW'(RX_TIMEOUT);
    localparam logic [TW-1:0]     TMO_ONE  = TW'(1);
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
    localparam logic [7:0] OP_WR  = 8'h01;
    localparam logic [7:0] OP_RD  = 8'h02;
    localparam logic [7:0] OP_RUN = 8'h03;
    localparam logic [7:0] RSP_WR  = 8'h5A;
    localparam logic [7:0] RSP_RUN = 8'hA5;
    localparam logic [7:0] RSP_ERR = 8'hEE;

    typedef enum logic [3:0] {
        IDLE, HDR_AH, HDR_AL, HDR_LEN, WR_DATA, CSUM,
        RD_REQ, RD_CAP, RD_SEND, RUN_GO, RUN_WAIT, RESP
    } state_t;

    state_t             state, state_next;
    logic [7:0]         op;
    logic [7:0]         addr_hi;
    logic [ADDR_W-1:0]  addr;
    logic [8:0]         cnt;
    logic [TW-1:0]      tmo;
    logic               load_tx;
    logic [7:0]         tx_byte;
    logic               set_err;
    logic               in_frame;
    logic               busy;
    logic               tx_accept;
`ifdef UART_HOST_CSUM_EN
    logic [7:0]         csum;
`endif

    assign in_frame   = (state == HDR_AH) || (state == HDR_AL) || (state == HDR_LEN) ||
                        (state == WR_DATA) || (state == CSUM);
    assign busy       = (state == RD_REQ) || (state == RD_CAP) || (state == RD_SEND) ||
                        (state == RUN_GO) || (state == RUN_WAIT) || (state == RESP);
    assign tx_accept  = tx_start && tx_ready;
    assign mem_re     = (state == RD_REQ);
    assign core_start = (state == RUN_GO);
    assign mem_addr   = addr;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_next;
    end

    // Next-state decode, reply byte selection and error detection
    always_comb begin
        state_next = state;
        load_tx    = 1'b0;
        tx_byte    = 8'h00;
        set_err    = rx_valid && busy;
        case (state)
            IDLE: if (rx_valid) begin
                if (rx_data == OP_WR || rx_data == OP_RD || rx_data == OP_RUN) begin
                    state_next = HDR_AH;
                end else begin
                    state_next = RESP;
                    load_tx    = 1'b1;
                    tx_byte    = RSP_ERR;
                    set_err    = 1'b1;
                end
            end
            HDR_AH:  if (rx_valid) state_next = HDR_AL;
            HDR_AL:  if (rx_valid) state_next = HDR_LEN;
            HDR_LEN: if (rx_valid) begin
`ifdef UART_HOST_CSUM_EN
                state_next = (op == OP_WR) ? WR_DATA : CSUM;
`else
                if (op == OP_WR)      state_next = WR_DATA;
                else if (op == OP_RD) state_next = RD_REQ;
                else                  state_next = RUN_GO;
`endif
            end
            WR_DATA: if (rx_valid && cnt == 9'd1) begin
`ifdef UART_HOST_CSUM_EN
                state_next = CSUM;
`else
                state_next = RESP;
                load_tx    = 1'b1;
                tx_byte    = RSP_WR;
`endif
            end
            CSUM: if (rx_valid) begin
`ifdef UART_HOST_CSUM_EN
                if (rx_data != csum) begin
                    state_next = RESP;
                    load_tx    = 1'b1;
                    tx_byte    = RSP_ERR;
                    set_err    = 1'b1;
                end else if (op == OP_WR) begin
                    state_next = RESP;
                    load_tx    = 1'b1;
                    tx_byte    = RSP_WR;
                end else if (op == OP_RD) begin
                    state_next = RD_REQ;
                end else begin
                    state_next = RUN_GO;
                end
`else
                state_next = IDLE;
`endif
            end
            RD_REQ: state_next = RD_CAP;
            RD_CAP: begin
                state_next = RD_SEND;
                load_tx    = 1'b1;
                tx_byte    = mem_rdata;
            end
            RD_SEND: if (tx_accept) state_next = (cnt == 9'd1) ? IDLE : RD_REQ;
            RUN_GO:  state_next = RUN_WAIT;
            RUN_WAIT: if (core_done) begin
                state_next = RESP;
                load_tx    = 1'b1;
                tx_byte    = RSP_RUN;
            end
            RESP: if (tx_accept) state_next = IDLE;
            default: state_next = IDLE;
        endcase
        // A silent sender aborts the frame without any reply
        if (in_frame && !rx_valid && tmo == TMO_MAX) begin
            state_next = IDLE;
            load_tx    = 1'b0;
            set_err    = 1'b1;
        end
    end

    // Datapath: header capture, write strobes, address/length counters, tx offer, timeout
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op         <= 8'h00;
            addr_hi    <= 8'h00;
            addr       <= '0;
            cnt        <= 9'd0;
            tmo        <= '0;
            tx_start   <= 1'b0;
            tx_data    <= 8'h00;
            mem_we     <= 1'b0;
            mem_wdata  <= '0;
            err_sticky <= 1'b0;
        end else begin
            mem_we <= 1'b0;
            if (set_err) err_sticky <= 1'b1;
            if (load_tx) tx_data <= tx_byte;
            // Offer goes up one cycle after the byte is registered and drops right after acceptance
            if (tx_start) begin
                if (tx_ready) tx_start <= 1'b0;
            end else if (state == RESP || state == RD_SEND) begin
                tx_start <= 1'b1;
            end
            // Address advances once the write it addressed has been presented
            if (mem_we) addr <= addr + ADDR_ONE;
            if (rx_valid || !in_frame) tmo <= '0;
            else if (tmo != TMO_MAX)   tmo <= tmo + TMO_ONE;
            case (state)
                IDLE:    if (rx_valid) op <= rx_data;
                HDR_AH:  if (rx_valid) addr_hi <= rx_data;
                HDR_AL:  if (rx_valid) addr <= ADDR_W'({addr_hi, rx_data});
                HDR_LEN: if (rx_valid) cnt <= (rx_data == 8'h00) ? 9'd256 : {1'b0, rx_data};
                WR_DATA: if (rx_valid) begin
                    mem_we    <= 1'b1;
                    mem_wdata <= rx_data;
                    cnt       <= cnt - 9'd1;
                end
                RD_SEND: if (tx_accept) begin
                    addr <= addr + ADDR_ONE;
                    cnt  <= cnt - 9'd1;
                end
                default: ;
            endcase
        end
    end

`ifdef UART_HOST_CSUM_EN
    // Running XOR of every frame byte, restarted by the opcode
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                       csum <= 8'h00;
        else if (rx_valid && state == IDLE) csum <= rx_data;
        else if (rx_valid)              csum <= csum ^ rx_data;
    end
`endif

endmodule
